// File: rtl/csr_bank_pkg.sv
// rtl/csr_bank_pkg.sv - shared types and constants for the machine-mode CSR bank
// Purpose: CSR operation and exception-cause enums, implemented CSR addresses,
//          interrupt cause numbers, mstatus bit positions and the CSR update helper.
// Ports:   none (package)
package csr_bank_pkg;

   typedef enum logic [1:0] {
      CSR_WRITE = 2'd0,
      CSR_SET   = 2'd1,
      CSR_CLEAR = 2'd2
   } csrOperation_e;

   typedef enum logic [3:0] {
      INSTR_ADDR_MISALIGNED = 4'd0,
      INSTR_ACCESS_FAULT    = 4'd1,
      ILLEGAL_INSTRUCTION   = 4'd2,
      BREAKPOINT            = 4'd3,
      LOAD_ADDR_MISALIGNED  = 4'd4,
      LOAD_ACCESS_FAULT     = 4'd5,
      STORE_ADDR_MISALIGNED = 4'd6,
      STORE_ACCESS_FAULT    = 4'd7,
      ECALL_M_MODE          = 4'd11
   } exceptionCode_e;

   typedef enum logic [11:0] {
      ADDR_MSTATUS   = 12'h300,
      ADDR_MIE       = 12'h304,
      ADDR_MTVEC     = 12'h305,
      ADDR_MSCRATCH  = 12'h340,
      ADDR_MEPC      = 12'h341,
      ADDR_MCAUSE    = 12'h342,
      ADDR_MTVAL     = 12'h343,
      ADDR_MIP       = 12'h344,
      ADDR_MCYCLE    = 12'hB00,
      ADDR_MINSTRET  = 12'hB02,
      ADDR_MCYCLEH   = 12'hB80,
      ADDR_MINSTRETH = 12'hB82,
      ADDR_CYCLE     = 12'hC00,
      ADDR_INSTRET   = 12'hC02,
      ADDR_CYCLEH    = 12'hC80,
      ADDR_INSTRETH  = 12'hC82,
      ADDR_MVENDORID = 12'hF11,
      ADDR_MARCHID   = 12'hF12,
      ADDR_MHARTID   = 12'hF14
   } csrAddr_e;

   localparam logic [4:0] IRQ_MEI = 5'd11;
   localparam logic [4:0] IRQ_MSI = 5'd3;
   localparam logic [4:0] IRQ_MTI = 5'd7;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   // Only MEI, MTI and MSI exist in mie/mip.
   localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

   function automatic logic [31:0] csr_apply(input csrOperation_e op,
                                             input logic [31:0] old_value,
                                             input logic [31:0] operand);
      case (op)
         CSR_WRITE: return operand;
         CSR_SET:   return old_value | operand;
         CSR_CLEAR: return old_value & ~operand;
         default:   return old_value;
      endcase
   endfunction

endpackage

// File: rtl/csr_bank_counter64.sv
// rtl/csr_bank_counter64.sv - 64-bit free-running counter with 32-bit half writes
// Purpose: backing store for mcycle/minstret; a half write replaces that half and
//          suppresses the increment of the whole counter for that cycle.
// Ports:   clk, reset (sync, active-high), i_enable (count), i_write_lo/i_write_hi,
//          i_data (value for the written half), o_count (current 64-bit value)
module counter64 (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_enable,
   input  logic        i_write_lo,
   input  logic        i_write_hi,
   input  logic [31:0] i_data,
   output logic [63:0] o_count
);

   logic [63:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_write_lo) begin
         r_count[31:0] <= i_data;
      end else if (i_write_hi) begin
         r_count[63:32] <= i_data;
      end else if (i_enable) begin
         r_count <= r_count + 64'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/csr_bank.sv
// rtl/csr_bank.sv - machine-mode CSR file and trap-state machine
// Purpose: holds the M-mode CSRs, serves CSR instructions, applies exception /
//          MRET / interrupt-ack updates from retire and exports trap targets.
// Ports:   clk, reset (sync, active-high); csr_* CSR instruction access;
//          raise_exception_i/exception_code_i, machine_return_i, interrupt_ack_i,
//          instruction_retired_i, pc_i, instruction_i from retire; irq_* level
//          requests; interrupt_pending_o to retire; mtvec_o/mepc_o to fetch.
module csr_bank
   import csr_bank_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           csr_read_enable_i,
   input  logic           csr_write_enable_i,
   input  csrOperation_e  csr_operation_i,
   input  logic [11:0]    csr_address_i,
   input  logic [31:0]    csr_data_i,
   output logic [31:0]    csr_data_o,
   input  logic           raise_exception_i,
   input  exceptionCode_e exception_code_i,
   input  logic           machine_return_i,
   input  logic           interrupt_ack_i,
   input  logic           instruction_retired_i,
   input  logic [31:0]    pc_i,
   input  logic [31:0]    instruction_i,
   input  logic           irq_external_i,
   input  logic           irq_timer_i,
   input  logic           irq_software_i,
   output logic           interrupt_pending_o,
   output logic [31:0]    mtvec_o,
   output logic [31:0]    mepc_o
);

   logic        r_mie_bit;
   logic        r_mpie;
   logic [31:0] r_mie;
   logic [31:0] r_mip;
   logic [31:0] r_mtvec;
   logic [31:0] r_mepc;
   logic [31:0] r_mcause;
   logic [31:0] r_mtval;
   logic [31:0] r_mscratch;

   logic [63:0] w_mcycle;
   logic [63:0] w_minstret;
   logic [31:0] w_mstatus;
   logic [31:0] w_rdata;
   logic [31:0] w_wdata;
   logic [31:0] w_irq_level;
   logic [31:0] w_ack_pc;
   logic [4:0]  w_irq_cause;

   always_comb begin
      w_mstatus               = '0;
      w_mstatus[12:11]        = 2'b11;
      w_mstatus[MSTATUS_MIE]  = r_mie_bit;
      w_mstatus[MSTATUS_MPIE] = r_mpie;
   end

   always_comb begin
      w_rdata = '0;
      case (csr_address_i)
         ADDR_MSTATUS:                 w_rdata = w_mstatus;
         ADDR_MIE:                     w_rdata = r_mie;
         ADDR_MTVEC:                   w_rdata = r_mtvec;
         ADDR_MSCRATCH:                w_rdata = r_mscratch;
         ADDR_MEPC:                    w_rdata = r_mepc;
         ADDR_MCAUSE:                  w_rdata = r_mcause;
         ADDR_MTVAL:                   w_rdata = r_mtval;
         ADDR_MIP:                     w_rdata = r_mip;
         ADDR_MCYCLE, ADDR_CYCLE:      w_rdata = w_mcycle[31:0];
         ADDR_MCYCLEH, ADDR_CYCLEH:    w_rdata = w_mcycle[63:32];
         ADDR_MINSTRET, ADDR_INSTRET:  w_rdata = w_minstret[31:0];
         ADDR_MINSTRETH, ADDR_INSTRETH: w_rdata = w_minstret[63:32];
         ADDR_MHARTID:                 w_rdata = MHARTID;
         default:                      w_rdata = '0;
      endcase
   end

   assign csr_data_o = csr_read_enable_i ? w_rdata : 32'h0;
   assign w_wdata    = csr_apply(csr_operation_i, w_rdata, csr_data_i);

   always_comb begin
      w_irq_level          = '0;
      w_irq_level[IRQ_MEI] = irq_external_i;
      w_irq_level[IRQ_MTI] = irq_timer_i;
      w_irq_level[IRQ_MSI] = irq_software_i;
   end

   // Cause priority MEI > MSI > MTI.
   always_comb begin
      if (r_mip[IRQ_MEI] & r_mie[IRQ_MEI]) begin
         w_irq_cause = IRQ_MEI;
      end else if (r_mip[IRQ_MSI] & r_mie[IRQ_MSI]) begin
         w_irq_cause = IRQ_MSI;
      end else if (r_mip[IRQ_MTI] & r_mie[IRQ_MTI]) begin
         w_irq_cause = IRQ_MTI;
      end else begin
         w_irq_cause = '0;
      end
   end

   // The interrupted instruction still completes, so return lands after it.
   assign w_ack_pc = pc_i + 32'd4;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mie_bit  <= 1'b0;
         r_mpie     <= 1'b0;
         r_mie      <= '0;
         r_mip      <= '0;
         r_mtvec    <= {MTVEC_RESET[31:2], 2'b00};
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_mtval    <= '0;
         r_mscratch <= '0;
      end else begin
         r_mip <= w_irq_level;

         if (csr_write_enable_i) begin
            case (csr_address_i)
               ADDR_MSTATUS: begin
                  r_mie_bit <= w_wdata[MSTATUS_MIE];
                  r_mpie    <= w_wdata[MSTATUS_MPIE];
               end
               ADDR_MIE:      r_mie      <= w_wdata & IRQ_MASK;
               ADDR_MTVEC:    r_mtvec    <= {w_wdata[31:2], 2'b00};
               ADDR_MSCRATCH: r_mscratch <= w_wdata;
               ADDR_MEPC:     r_mepc     <= {w_wdata[31:2], 2'b00};
               ADDR_MCAUSE:   r_mcause   <= w_wdata;
               ADDR_MTVAL:    r_mtval    <= w_wdata;
               default: ;
            endcase
         end

         // Trap/MRET updates are placed after the CSR write so they take
         // precedence on mstatus, mepc, mcause and mtval.
         if (raise_exception_i) begin
            r_mepc    <= {pc_i[31:2], 2'b00};
            r_mcause  <= {1'b0, 27'b0, exception_code_i};
            r_mtval   <= (exception_code_i == ILLEGAL_INSTRUCTION) ? instruction_i : 32'h0;
            r_mpie    <= r_mie_bit;
            r_mie_bit <= 1'b0;
         end else if (machine_return_i) begin
            r_mie_bit <= r_mpie;
            r_mpie    <= 1'b1;
         end else if (interrupt_ack_i) begin
            r_mepc    <= {w_ack_pc[31:2], 2'b00};
            r_mcause  <= {1'b1, 26'b0, w_irq_cause};
            r_mtval   <= '0;
            r_mpie    <= r_mie_bit;
            r_mie_bit <= 1'b0;
         end
      end
   end

   counter64 u_mcycle (
      .clk        (clk),
      .reset      (reset),
      .i_enable   (1'b1),
      .i_write_lo (csr_write_enable_i && (csr_address_i == ADDR_MCYCLE)),
      .i_write_hi (csr_write_enable_i && (csr_address_i == ADDR_MCYCLEH)),
      .i_data     (w_wdata),
      .o_count    (w_mcycle)
   );

   counter64 u_minstret (
      .clk        (clk),
      .reset      (reset),
      .i_enable   (instruction_retired_i),
      .i_write_lo (csr_write_enable_i && (csr_address_i == ADDR_MINSTRET)),
      .i_write_hi (csr_write_enable_i && (csr_address_i == ADDR_MINSTRETH)),
      .i_data     (w_wdata),
      .o_count    (w_minstret)
   );

   assign interrupt_pending_o = r_mie_bit & |(r_mip & r_mie);
   assign mtvec_o             = r_mtvec;
   assign mepc_o              = r_mepc;

endmodule

// File: tb/tb_csr_bank.sv
// tb/tb_csr_bank.sv - scoreboard bench for csr_bank with directed and random stimulus
module tb_csr_bank;
   import csr_bank_pkg::*;

   localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
   localparam logic [31:0] HART      = 32'h0000_0005;

   logic           clk = 1'b0;
   logic           reset;
   logic           csr_read_enable_i, csr_write_enable_i;
   csrOperation_e  csr_operation_i;
   logic [11:0]    csr_address_i;
   logic [31:0]    csr_data_i, csr_data_o;
   logic           raise_exception_i;
   exceptionCode_e exception_code_i;
   logic           machine_return_i, interrupt_ack_i, instruction_retired_i;
   logic [31:0]    pc_i, instruction_i;
   logic           irq_external_i, irq_timer_i, irq_software_i;
   logic           interrupt_pending_o;
   logic [31:0]    mtvec_o, mepc_o;

   always #5 clk = ~clk;

   csr_bank #(.MTVEC_RESET(MTVEC_RST), .MHARTID(HART)) dut (
      .clk(clk), .reset(reset),
      .csr_read_enable_i(csr_read_enable_i), .csr_write_enable_i(csr_write_enable_i),
      .csr_operation_i(csr_operation_i), .csr_address_i(csr_address_i),
      .csr_data_i(csr_data_i), .csr_data_o(csr_data_o),
      .raise_exception_i(raise_exception_i), .exception_code_i(exception_code_i),
      .machine_return_i(machine_return_i), .interrupt_ack_i(interrupt_ack_i),
      .instruction_retired_i(instruction_retired_i), .pc_i(pc_i),
      .instruction_i(instruction_i), .irq_external_i(irq_external_i),
      .irq_timer_i(irq_timer_i), .irq_software_i(irq_software_i),
      .interrupt_pending_o(interrupt_pending_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o)
   );

   // kind: 0 csr_data_o, 1 mepc_o, 2 mtvec_o, 3 interrupt_pending_o
   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   logic        m_ie, m_pie;
   logic [31:0] m_mie, m_mip, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
   logic [63:0] m_cycle, m_instret;

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (32'(m_pie) << 7) | (32'(m_ie) << 3);
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return m_mip;
         12'hB00, 12'hC00: return m_cycle[31:0];
         12'hB80, 12'hC80: return m_cycle[63:32];
         12'hB02, 12'hC02: return m_instret[31:0];
         12'hB82, 12'hC82: return m_instret[63:32];
         12'hF14: return HART;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit m_writable(input logic [11:0] a);
      case (a)
         12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
         12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic m_pending();
      return m_ie & |(m_mip & m_mie);
   endfunction

   task automatic model_reset();
      m_ie = 0; m_pie = 0; m_mie = 0; m_mip = 0; m_mtvec = MTVEC_RST;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
      m_cycle = 0; m_instret = 0;
   endtask

   // Applies one clock edge worth of architectural effects to the model.
   task automatic model_edge();
      logic [31:0] old_v, nv, pend;
      logic        wr, old_ie, old_pie;
      int          cause;
      if (reset) begin
         model_reset();
         return;
      end
      old_ie  = m_ie;
      old_pie = m_pie;
      old_v   = m_read(csr_address_i);
      wr      = csr_write_enable_i && m_writable(csr_address_i);
      if (csr_operation_i == CSR_WRITE)      nv = csr_data_i;
      else if (csr_operation_i == CSR_SET)   nv = old_v | csr_data_i;
      else                                   nv = old_v & ~csr_data_i;
      pend  = m_mip & m_mie;
      cause = pend[11] ? 11 : pend[3] ? 3 : pend[7] ? 7 : 0;

      if (wr && csr_address_i == 12'hB00)      m_cycle[31:0]  = nv;
      else if (wr && csr_address_i == 12'hB80) m_cycle[63:32] = nv;
      else                                     m_cycle = m_cycle + 1;
      if (wr && csr_address_i == 12'hB02)      m_instret[31:0]  = nv;
      else if (wr && csr_address_i == 12'hB82) m_instret[63:32] = nv;
      else if (instruction_retired_i)          m_instret = m_instret + 1;

      if (wr) begin
         case (csr_address_i)
            12'h300: begin m_ie = nv[3]; m_pie = nv[7]; end
            12'h304: m_mie      = nv & 32'h888;
            12'h305: m_mtvec    = nv & 32'hFFFF_FFFC;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
            12'h342: m_mcause   = nv;
            12'h343: m_mtval    = nv;
            default: ;
         endcase
      end

      if (raise_exception_i) begin
         m_mepc   = pc_i & 32'hFFFF_FFFC;
         m_mcause = 32'(exception_code_i);
         m_mtval  = (exception_code_i == ILLEGAL_INSTRUCTION) ? instruction_i : 0;
         m_pie = old_ie; m_ie = 0;
      end else if (machine_return_i) begin
         m_ie = old_pie; m_pie = 1;
      end else if (interrupt_ack_i) begin
         m_mepc   = (pc_i + 4) & 32'hFFFF_FFFC;
         m_mcause = 32'h8000_0000 | 32'(cause);
         m_mtval  = 0;
         m_pie = old_ie; m_ie = 0;
      end

      m_mip = (32'(irq_external_i) << 11) | (32'(irq_timer_i) << 7) | (32'(irq_software_i) << 3);
   endtask

   task automatic clear_inputs();
      csr_read_enable_i = 0; csr_write_enable_i = 0; csr_operation_i = CSR_WRITE;
      csr_address_i = 0; csr_data_i = 0; raise_exception_i = 0;
      exception_code_i = INSTR_ADDR_MISALIGNED; machine_return_i = 0;
      interrupt_ack_i = 0; instruction_retired_i = 0; pc_i = 0; instruction_i = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      clear_inputs();
   endtask

   task automatic exp_rd(input logic [11:0] a, input logic [31:0] v, input string nm);
      csr_read_enable_i = 1;
      csr_address_i     = a;
      q.push_back('{0, v, nm});
   endtask

   task automatic exp_out(input int k, input logic [31:0] v, input string nm);
      csr_read_enable_i = 1;
      q.push_back('{k, v, nm});
   endtask

   task automatic wr(input logic [11:0] a, input csrOperation_e op, input logic [31:0] d);
      csr_write_enable_i = 1; csr_address_i = a; csr_operation_i = op; csr_data_i = d;
   endtask

   // Monitor: the DUT presents data whenever a read is enabled.
   always @(negedge clk) begin : monitor
      chk_t        c;
      logic [31:0] act;
      if (csr_read_enable_i) begin
         while (q.size() > 0) begin
            c = q.pop_front();
            case (c.kind)
               0:       act = csr_data_o;
               1:       act = mepc_o;
               2:       act = mtvec_o;
               default: act = {31'b0, interrupt_pending_o};
            endcase
            n_checks++;
            if (act !== c.exp) begin
               n_fail++;
               $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   logic [11:0] addr_list [21] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
      12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
      12'hC80, 12'hC02, 12'hC82, 12'hF11, 12'hF12, 12'hF14, 12'h7C0, 12'h301};
   exceptionCode_e code_list [5] = '{ILLEGAL_INSTRUCTION, BREAKPOINT,
      LOAD_ACCESS_FAULT, ECALL_M_MODE, STORE_ADDR_MISALIGNED};

   initial begin
      clear_inputs();
      irq_external_i = 1; irq_timer_i = 0; irq_software_i = 0;
      reset = 1;
      tick(); tick();
      reset = 0;

      // irq held through reset is only seen one cycle after release
      exp_rd(12'h344, 32'h0, "mip_after_reset"); exp_out(3, 0, "pend_reset"); tick();
      exp_rd(12'h344, 32'h800, "mip_sampled"); irq_external_i = 0; tick();
      exp_rd(12'h305, MTVEC_RST, "mtvec_reset"); exp_out(2, MTVEC_RST, "mtvec_o_reset"); tick();
      exp_rd(12'h300, 32'h1800, "mstatus_reset"); exp_out(1, 0, "mepc_o_reset"); tick();
      exp_rd(12'hF14, HART, "mhartid"); tick();
      wr(12'hF14, CSR_WRITE, 32'h1234); tick();
      exp_rd(12'hF14, HART, "mhartid_ro"); tick();

      // Exception with MIE=1
      wr(12'h300, CSR_WRITE, 32'h8); tick();
      raise_exception_i = 1; exception_code_i = ILLEGAL_INSTRUCTION;
      pc_i = 32'h100; instruction_i = 32'hFFFF_FFFF; tick();
      exp_out(1, 32'h100, "exc_mepc_o"); exp_rd(12'h342, 32'h2, "exc_mcause"); tick();
      exp_rd(12'h343, 32'hFFFF_FFFF, "exc_mtval"); tick();
      exp_rd(12'h300, 32'h1880, "exc_mstatus"); tick();
      machine_return_i = 1; tick();
      exp_rd(12'h300, 32'h1888, "mret_mstatus"); tick();

      // Interrupt: pending rises one cycle after irq, ack picks MEI
      wr(12'h304, CSR_WRITE, 32'h888); tick();
      irq_timer_i = 1; irq_external_i = 1;
      exp_out(3, 0, "pend_latency"); tick();
      exp_out(3, 1, "pend_rise"); interrupt_ack_i = 1; pc_i = 32'h200; tick();
      exp_out(1, 32'h204, "ack_mepc_o"); exp_rd(12'h342, 32'h8000_000B, "ack_mcause");
      exp_out(3, 0, "pend_drop"); irq_timer_i = 0; irq_external_i = 0; tick();
      exp_rd(12'h300, 32'h1880, "ack_mstatus"); tick();

      // Exception wins over a same-cycle SET of MIE
      wr(12'h300, CSR_SET, 32'h8); raise_exception_i = 1;
      exception_code_i = BREAKPOINT; pc_i = 32'h302; tick();
      exp_rd(12'h300, 32'h1800, "exc_vs_set_mstatus"); exp_out(1, 32'h300, "exc_mepc_mask"); tick();
      exp_rd(12'h343, 32'h0, "exc_mtval_zero"); tick();

      // Counter wrap
      wr(12'hB00, CSR_WRITE, 32'hFFFF_FFFF); tick();
      wr(12'hB80, CSR_WRITE, 32'hFFFF_FFFF); tick();
      tick(); tick();
      exp_rd(12'hB00, 32'h1, "mcycle_wrap_lo"); tick();
      exp_rd(12'hB80, 32'h0, "mcycle_wrap_hi"); tick();
      exp_rd(12'hC00, 32'h3, "cycle_shadow"); tick();

      // minstret: 3 retire pulses, then write beats retire
      repeat (3) begin instruction_retired_i = 1; tick(); end
      exp_rd(12'hB02, 32'h3, "minstret_3"); tick();
      wr(12'hB02, CSR_WRITE, 32'h10); instruction_retired_i = 1; tick();
      exp_rd(12'hC02, 32'h10, "minstret_write_wins"); tick();

      // Masks and unimplemented addresses
      wr(12'h305, CSR_WRITE, 32'h7); tick();
      exp_rd(12'h305, 32'h4, "mtvec_mask"); exp_out(2, 32'h4, "mtvec_o_mask"); tick();
      irq_software_i = 1; wr(12'h344, CSR_WRITE, 32'hFFFF); tick();
      exp_rd(12'h344, 32'h8, "mip_ro"); tick();
      exp_rd(12'h7C0, 32'h0, "unimpl_read"); irq_software_i = 0; tick();

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         irq_external_i = ($urandom_range(0, 3) == 0);
         irq_timer_i    = ($urandom_range(0, 3) == 0);
         irq_software_i = ($urandom_range(0, 3) == 0);
         instruction_retired_i = $urandom_range(0, 1);
         pc_i = $urandom; instruction_i = $urandom;
         exception_code_i = code_list[$urandom_range(0, 4)];
         case ($urandom_range(0, 11))
            0: raise_exception_i = 1;
            1: machine_return_i = 1;
            2: interrupt_ack_i = 1;
            3: begin raise_exception_i = 1; interrupt_ack_i = 1; machine_return_i = 1; end
            default: ;
         endcase
         csr_address_i = addr_list[$urandom_range(0, 20)];
         if ($urandom_range(0, 1) == 1)
            wr(csr_address_i, csrOperation_e'($urandom_range(0, 2)),
               ($urandom_range(0, 1) == 1) ? $urandom : 32'h888);
         exp_rd(csr_address_i, m_read(csr_address_i), "rand_read");
         exp_out(1, m_mepc, "rand_mepc_o");
         exp_out(2, m_mtvec, "rand_mtvec_o");
         exp_out(3, {31'b0, m_pending()}, "rand_pending");
         tick();
      end

      // Reset in mid-operation with irqs asserted
      irq_external_i = 1; irq_timer_i = 1; irq_software_i = 1;
      wr(12'h340, CSR_WRITE, 32'hDEAD_BEEF); reset = 1; tick();
      reset = 0;
      exp_rd(12'hB00, 32'h0, "reset_mcycle"); exp_out(2, MTVEC_RST, "reset_mtvec_o"); tick();
      exp_rd(12'h344, 32'h888, "reset_mip_late"); tick();
      exp_rd(12'h340, 32'h0, "reset_mscratch"); exp_out(3, 0, "reset_pending"); tick();

      tick();
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
